// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch constants and the discard FSM state type.
//   RESET_PC_DEF : default reset PC
//   INSTR_W      : instruction word width
//   PC_INC       : sequential PC increment
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] PC_INC       = 32'd4;

    // RUN: no wrong-path responses pending; DRAIN: discard_cnt > 0
    typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush and count.
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the FIFO; wins over push, a same-cycle pop still completes
//   push, din  : write din at the tail
//   pop        : drop the head (caller only pops when count != 0)
//   dout       : head entry, 0 when empty
//   count      : number of entries held
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // Storage is not reset, so an empty FIFO presents zeros
    assign dout = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with in-order imem requests,
// {pc, instr} buffer to decode and redirect with wrong-path discard.
//   clk, rst_n                  : clock, async active-low reset
//   redirect_valid, redirect_pc : resolved non-sequential target
//   imem_req/addr/gnt           : fetch request channel
//   imem_rvalid/rdata           : in-order response channel
//   id_valid/ready/pc/instr     : handshake to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_pc,
    output logic [INSTR_W-1:0] id_instr
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state, state_nxt;
    logic [31:0]           pc, tag;
    logic [CW-1:0]         outstanding, occupancy, discard_cnt, discard_nxt;
    logic [CW+1:0]         credit_used;
    logic [32+INSTR_W-1:0] head;
    logic                  grant, rsp, drop, xfer;

    assign xfer        = id_valid && id_ready;
    // A head leaving this cycle frees its slot, which sustains one fetch per cycle
    assign credit_used = (CW+2)'(outstanding) + (CW+2)'(occupancy)
                       + (CW+2)'(discard_cnt) - (CW+2)'(xfer);
    assign imem_req    = rst_n && (credit_used < (CW+2)'(DEPTH));
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    // Responses with nothing outstanding (e.g. left over from before reset) are ignored
    assign rsp         = imem_rvalid && (outstanding != '0);
    assign drop        = rsp && (state == DRAIN || redirect_valid);
    assign id_valid    = occupancy != '0;
    assign id_pc       = head[32+INSTR_W-1:INSTR_W];
    assign id_instr    = head[INSTR_W-1:0];

    fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_tag_q (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .push(grant), .din(pc), .pop(rsp),
        .dout(tag), .count(outstanding)
    );

    fetch_fifo #(.DEPTH(DEPTH), .W(32+INSTR_W)) u_buf (
        .clk(clk), .rst_n(rst_n), .flush(redirect_valid),
        .push(rsp && !drop), .din({tag, imem_rdata}), .pop(xfer),
        .dout(head), .count(occupancy)
    );

    // On redirect every fetch still outstanding after this cycle is wrong-path
    always_comb begin
        discard_nxt = discard_cnt;
        state_nxt   = state;
        if (redirect_valid) discard_nxt = outstanding + CW'(grant) - CW'(rsp);
        else if (drop) discard_nxt = discard_cnt - 1'b1;
        state_nxt = (discard_nxt != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            discard_cnt <= '0;
            state       <= RUN;
        end else begin
            pc          <= redirect_valid ? (redirect_pc & ~32'h3) : grant ? pc + PC_INC : pc;
            discard_cnt <= discard_nxt;
            state       <= state_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, hand-sequenced and random checks of fetch_unit against a stream model.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    typedef struct packed {
        logic        g, r, rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    rsp_t        mq[$];
    vec_t        tbl [19];
    int          checks = 0, errors = 0, cyc = 0, last_due = 0, lat = 1, xfers = 0;
    logic [31:0] mpc, exp_id;
    logic        post_redir = 1'b0;
    logic        o_req, o_v;
    logic [31:0] o_addr, o_pc, o_instr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        id_ready = 1'b0;
        #1;
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_pc"}, id_pc, 32'd0);
        chk({tag, "_instr"}, id_instr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        mpc = RST_PC;
        exp_id = RST_PC;
        post_redir = 1'b0;
        last_due = cyc;
    endtask

    // One clock cycle: drive inputs, answer from the memory model, check the stream model
    task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rpc,
                        input bit spur = 1'b0);
        bit mem_rv;
        int due;
        imem_gnt = g;
        id_ready = r;
        redirect_valid = rd;
        redirect_pc = rpc;
        mem_rv = !spur && mq.size() > 0 && mq[0].due <= cyc;
        imem_rvalid = spur || mem_rv;
        imem_rdata = spur ? 32'hDEAD_BEEF : mem_rv ? word(mq[0].addr) : 32'd0;
        #4;
        o_req = imem_req;
        o_addr = imem_addr;
        o_v = id_valid;
        o_pc = id_pc;
        o_instr = id_instr;
        if (post_redir) begin
            chk("after_redirect_valid", 32'(o_v), 32'd0);
            chk("after_redirect_addr", o_addr, mpc);
        end
        post_redir = rd;
        if (o_v && r) begin
            chk("stream_pc", o_pc, exp_id);
            chk("stream_instr", o_instr, word(exp_id));
            exp_id += 4;
            xfers++;
        end
        if (o_req) chk("req_addr", o_addr, mpc);
        if (mem_rv) void'(mq.pop_front());
        if (o_req && g) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mq.push_back('{addr: o_addr, due: due});
            chk("credit_bound", 32'(mq.size() <= DEPTH), 32'd1);
            mpc += 4;
        end
        if (rd) begin
            mpc = rpc & ~32'h3;
            exp_id = mpc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_in_flight();
        for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("two_in_flight", 32'(mq.size()), 32'd2);
    endtask

    initial begin
        logic [31:0] first_pc;
        bit          saw_hi, saw_wrap;
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3004, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3008, 1'b1, 32'h3000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h300C, 1'b1, 32'h3004};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3010, 1'b1, 32'h3008};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3014, 1'b1, 32'h300C};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3018, 1'b1, 32'h3010};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h301C, 1'b1, 32'h3014};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h301C, 1'b1, 32'h3018};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3020, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3024, 1'b1, 32'h301C};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h4001, 1'b1, 32'h3028, 1'b1, 32'h3020};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h4000, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h4000, 1'b0, 32'h0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h4004, 1'b0, 32'h0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h4008, 1'b1, 32'h4000};

        #2;
        // 1-cycle memory: streaming, stall with id_ready=0, redirect with grant and rvalid
        lat = 1;
        do_reset("reset");
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].g, tbl[i].r, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("tbl%0d_req", i), 32'(o_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(o_v), 32'(tbl[i].v));
            if (tbl[i].v) chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].pc);
        end

        // Wrap of the PC past 0xFFFF_FFFC
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        saw_hi = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (saw_hi && o_req && o_addr == 32'h0) saw_wrap = 1'b1;
            if (o_req && o_addr == 32'hFFFF_FFFC) saw_hi = 1'b1;
        end
        chk("pc_wrap", {30'd0, saw_hi, saw_wrap}, 32'd3);

        // 3-cycle memory: redirect with two fetches in flight
        lat = 3;
        do_reset("reset2");
        fill_in_flight();
        step(1'b1, 1'b1, 1'b1, 32'h0000_4001);
        first_pc = 32'd0;
        for (int i = 0; i < 30 && first_pc == 32'd0; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (o_v) first_pc = o_pc;
        end
        chk("redirect_first_pc", first_pc, 32'h0000_4000);

        // Reset asserted mid-DRAIN, then a stale response after release
        do_reset("reset3");
        fill_in_flight();
        step(1'b1, 1'b1, 1'b1, 32'h0000_5000);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        #2;
        do_reset("async_reset");
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("post_reset_req", 32'(o_req), 32'd1);
        chk("post_reset_addr", o_addr, RST_PC);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("stale_rsp_ignored", 32'(o_v), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Random traffic against the stream model
        do_reset("reset4");
        xfers = 0;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom);
        end
        chk("random_progress", 32'(xfers > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end. Holds the architectural PC, issues in-order instruction-memory requests, buffers returned words with their PCs, and hands {pc, instr} to decode over a valid/ready handshake. Consumes the branch unit's resolved target as a redirect: the PC is reloaded and all wrong-path fetches, whether in flight or buffered, are discarded.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded at reset.
- `DEPTH`, default 2: fetch buffer entries; also the maximum outstanding-plus-buffered fetches. Power of two, ≥2.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `redirect_valid`  in  1: branch/jump resolved to a non-sequential target this cycle.
- `redirect_pc`  in  32: new fetch address. Bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address; equals the current PC.
- `imem_gnt`  in  1: request accepted this cycle. Sampled only while `imem_req`=1.
- `imem_rvalid`  in  1: response word valid. Responses arrive in order, ≥1 cycle after grant.
- `imem_rdata`  in  32: instruction word.
- `id_valid`  out  1: buffer head is valid.
- `id_ready`  in  1: decode accepts the head.
- `id_pc`  out  32: PC of the head instruction.
- `id_instr`  out  32: head instruction word.

## Operation
- Credit rule: `imem_req` = (outstanding + occupancy + pending_discard < DEPTH). No request is ever issued without guaranteed buffer space.
- Grant (`imem_req`&`imem_gnt`):
  - Push PC into the in-flight PC tag queue (DEPTH entries).
  - pc ← pc+4. Wraps modulo 2^32.
  - outstanding++.
- Response (`imem_rvalid`):
  - If discard_cnt>0: drop the word, pop its tag, discard_cnt--.
  - Otherwise: push {tag, rdata} into the buffer and pop the tag.
  - Either way, outstanding--.
- Decode transfer (`id_valid`&`id_ready`): pop the buffer head.
- Redirect (`redirect_valid`=1):
  - pc ← {redirect_pc[31:2],2'b00}.
  - Buffer flushed. Occupancy becomes 0 after this cycle.
  - discard_cnt ← all fetches outstanding after this cycle, including a grant in the same cycle, minus any response consumed this cycle.
- Simultaneous events in the redirect cycle:
  - Grant in the same cycle: the granted request is wrong-path and is counted into discard_cnt. pc takes the redirect, not pc+4.
  - `imem_rvalid` in the same cycle: the word is dropped.
  - Decode handshake in the same cycle: the transfer completes. `id_valid` is not masked; decode kills it using its own flush.
  - Back-to-back redirects: each accumulates discard_cnt correctly. The last redirect wins the PC.
- Discard state: states RUN and DRAIN.
  - DRAIN while discard_cnt>0. New requests from the redirected PC may issue during DRAIN, within credit.
  - DRAIN→RUN when discard_cnt reaches 0.
- Spurious `imem_rvalid` with outstanding=0 is ignored. Assertion in the bench.

## Timing
- Reset values (async assert):
  - pc = RESET_PC.
  - outstanding, occupancy, discard_cnt = 0.
  - `imem_req` = 0 while `rst_n`=0.
  - `id_valid` = 0.
  - `id_pc` = 0, `id_instr` = 0.
  - State = RUN.
- First request: `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle after reset deassertion.
- Latency: response word visible on `id_valid` the cycle after `imem_rvalid`, since the buffer write is registered.
- Throughput: with 1-cycle memory latency and `id_ready`=1, one instruction per cycle.
- Redirect: new `imem_addr` is presented the cycle after `redirect_valid`. The buffer is empty (`id_valid`=0) that cycle.
- Full buffer with `id_ready`=0: `imem_req` stays 0, and `imem_addr`/`id_*` hold stable.
- Reset mid-operation clears all counters immediately. Responses still arriving after reset release with outstanding=0 are ignored.

## Structure
- Shared defines header holds the fetch constants: RESET_PC default, instruction width 32, PC increment 4.
- One sub-module, `fetch_fifo`: parameterised DEPTH synchronous FIFO with push, pop, flush and count.
  - Instantiated twice: once for the PC tag queue (32 bits) and once for the {pc,instr} buffer (64 bits).
  - Flush takes priority over push; a pop in the same cycle is still reported as completed.
- Top level holds the PC register, credit logic, discard counter and RUN/DRAIN FSM.

## Test plan
- Reset, then 1-cycle memory with `imem_gnt`=1 and `id_ready`=1 → `id_pc` = 0x3000, 0x3004, 0x3008 on consecutive cycles, with instructions matching memory.
- Hold `id_ready`=0 → at most 2 grants issued, `imem_req` falls to 0, and `id_pc`=0x3000 holds stable. Release → sequential resume with no loss or duplication.
- Redirect to 0x0000_4001 while 2 fetches are in flight (3-cycle latency) → both returned words dropped, next `id_pc`=0x4000, and no stale PC appears.
- Redirect in the same cycle as a grant and as `imem_rvalid` → both are discarded, discard_cnt returns to 0, and the FSM ends in RUN.
- PC at 0xFFFF_FFFC with sequential fetch → next `imem_addr`=0x0000_0000.
- Assert `rst_n`=0 mid-DRAIN → all outputs return to their reset values asynchronously, and after release the first fetch is from RESET_PC.
